// File: rtl/seq_divider_if.sv
// Handshake/result bundle for seq_divider: operands and start in, status and results out.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_DIV_ZERO_EN: short-circuits divisor==0 and raises div_by_zero.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Trial subtraction is modulo 2^(WIDTH+1); the MSB acts as the borrow.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] s,
                                               input logic [WIDTH-1:0] dv);
    return s - {1'b0, dv};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    dbz_d   = dbz_q;
`endif
    shifted = {r_q, q_q[WIDTH-1]};
    trial   = trial_sub(shifted, d_q);

    case (state_q)
      S_RUN: begin
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        // Results become visible only when the final bit has been resolved.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          quo_d   = q_d;
          rem_d   = r_d;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          q_d     = bus.dividend;
          r_d     = '0;
          d_d     = bus.divisor;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          dbz_d   = 1'b0;
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider for unsigned operands. It is built from one WIDTH+1-bit subtract stage per cycle, and serves as the inverse-arithmetic counterpart to the team's ripple-carry adder datapath. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It then presents quotient and remainder with a one-cycle done strobe for the controller FSM that consumes arithmetic results.

## Interface
- WIDTH, 8, operand/result width in bits (≥2); iteration counter is $clog2(WIDTH+1) bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- busy  output  1  high while an operation is in progress (state RUN)
- done  output  1  one-cycle result-valid strobe
- quotient  output  WIDTH  unsigned quotient, held until next accepted start
- remainder  output  WIDTH  unsigned remainder, held until next accepted start
- div_by_zero  output  1  zero-divisor flag (see Configuration; constant 0 when feature is out)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, counter 0, internal registers 0.
- IDLE/DONE + start=1: capture operands; Q←dividend, R←0, D←divisor, cnt←0; → RUN.
- IDLE + start=0: stay. DONE + start=0: → IDLE.
- RUN, each cycle: shifted = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits); trial = shifted − {1'b0, D} (WIDTH+1 bits).
  - trial MSB=0: R←trial[WIDTH-1:0], Q←{Q[WIDTH-2:0],1}.
  - trial MSB=1: R←shifted[WIDTH-1:0], Q←{Q[WIDTH-2:0],0}.
  - cnt←cnt+1; when cnt==WIDTH-1 this is the last iteration → DONE.
- quotient/remainder are updated from Q/R on the RUN→DONE transition only. They hold across IDLE and across the next RUN until that operation completes.
- start while busy=1: ignored, with no effect on operands or progress.
- divisor=0 with the feature compiled out: the natural algorithm result applies, quotient = all ones and remainder = dividend.
- All arithmetic is unsigned modulo 2^(WIDTH+1) inside the trial stage; no overflow is possible in results.

## Timing
- Start accepted at edge E0 → busy=1 from E0 through E(WIDTH); done=1 for exactly one cycle after E(WIDTH).
- Latency: start-accept edge to done-high = WIDTH+1 edges (9 for WIDTH=8).
- done is high in the DONE state only; busy and done are never simultaneously high.
- Back-to-back: start=1 during the done cycle is accepted; busy rises the next cycle, giving a throughput of one result per WIDTH+1 cycles.
- rst=1 at any edge (including mid-RUN): IDLE next cycle, and busy, done, quotient, remainder, and div_by_zero are all 0. The partial operation is discarded.
- rst has priority over start on the same edge.

## Configuration
- Macro: SEQ_DIVIDER_DIV_ZERO_EN.
- Defined: an accepted start with divisor==0 goes straight to DONE; RUN is skipped. On the next edge, done=1, div_by_zero=1, quotient=all ones, remainder=dividend, with a latency of 1 edge. div_by_zero is cleared on the next accepted start or on rst, and is 0 for any nonzero divisor.
- Undefined: div_by_zero is tied to 0, and divisor=0 runs the full WIDTH iterations with the result stated in Operation.

## Test plan
- 200/7, WIDTH=8 → done 9 cycles after start; quotient=28, remainder=4, busy high for 8 cycles.
- 255/1 then 5/9 back-to-back, with start asserted during the first done cycle → 255 r 0, then 0 r 5; second done exactly 9 cycles after the first.
- start pulsed with 100/3 while busy mid-run of 200/7 → result remains 28 r 4; second request ignored.
- rst asserted on cycle 4 of RUN → next cycle busy=0, done=0, quotient=0, remainder=0; a subsequent 17/4 yields 4 r 1.
- 37/0 with macro undefined → 9 cycles, quotient=0xFF, remainder=37, div_by_zero=0. With macro defined → done on next edge, quotient=0xFF, remainder=37, div_by_zero=1; a following 9/3 gives 3 r 0 with div_by_zero=0.
- Random sweep of 10,000 operand pairs (divisor≠0) → quotient*divisor+remainder==dividend and remainder<divisor on every done.
